// File: rtl/fpga_io_router.sv
// Wishbone-programmable pad crossbar between the fpga250 GPIO bus and the Caravel user pads.
// Define IO_ROUTER_SYNC_EN to put a 2-flop synchroniser on every pad input before the fabric mux.
module fpga_io_router #(
   parameter int unsigned NUM_PADS    = 38,
   parameter int unsigned NUM_FPGA_IO = 38,
   parameter int unsigned SEL_W       = 6,
   parameter logic [31:0] BASE_ADDR   = 32'h3000_1000
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   wbs_stb_i,
   input  logic                   wbs_cyc_i,
   input  logic                   wbs_we_i,
   input  logic [3:0]             wbs_sel_i,
   input  logic [31:0]            wbs_dat_i,
   input  logic [31:0]            wbs_adr_i,
   output logic                   wbs_ack_o,
   output logic [31:0]            wbs_dat_o,
   input  logic [NUM_FPGA_IO-1:0] fpga_out,
   output logic [NUM_FPGA_IO-1:0] fpga_in,
   input  logic [NUM_PADS-1:0]    io_in,
   output logic [NUM_PADS-1:0]    io_out,
   output logic [NUM_PADS-1:0]    io_oeb
);

   localparam int unsigned SEL_SPAN = 1 << SEL_W;
   localparam int unsigned WORD_W   = 10;
   localparam int unsigned BIT_DIR  = 8;
   localparam int unsigned BIT_EN   = 9;
   localparam logic [WORD_W-1:0] CTRL_WORD = WORD_W'(10'h040);

   typedef struct packed {
      logic             en;
      logic             dir;
      logic [SEL_W-1:0] sel;
   } pad_cfg_t;

   typedef enum logic {
      S_IDLE,
      S_ACK
   } state_t;

   pad_cfg_t            cfg_q [NUM_PADS];
   logic                lock_q;
   state_t              state_q, state_d;
   logic                ack_d;
   logic [31:0]         dat_d;
   logic                hit, req, wr_commit;
   logic                ctrl_hit;
   logic [WORD_W-1:0]   word;
   logic [31:0]         rd_data;
   logic [SEL_SPAN-1:0] fpga_out_ext;
   logic [NUM_PADS-1:0] pad_in;
   logic                unused_bits;

   assign hit      = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
   assign req      = wbs_stb_i & wbs_cyc_i & hit;
   assign word     = wbs_adr_i[11:2];
   assign ctrl_hit = (word == CTRL_WORD);

   // Zero-extend so any select value indexes safely; range is still qualified below.
   assign fpga_out_ext = SEL_SPAN'(fpga_out);

   assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

`ifdef IO_ROUTER_SYNC_EN
   logic [NUM_PADS-1:0] sync1_q, sync2_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= io_in;
         sync2_q <= sync1_q;
      end
   end

   assign pad_in = sync2_q;
`else
   assign pad_in = io_in;
`endif

   // Read mux: pad registers, control register, everything else reads zero.
   always_comb begin
      rd_data = '0;
      if (ctrl_hit) begin
         rd_data[0] = lock_q;
      end
      for (int p = 0; p < NUM_PADS; p++) begin
         if (word == WORD_W'(p)) begin
            rd_data[SEL_W-1:0] = cfg_q[p].sel;
            rd_data[BIT_DIR]   = cfg_q[p].dir;
            rd_data[BIT_EN]    = cfg_q[p].en;
         end
      end
   end

   // Bus FSM: one registered ack per accepted request, then back to idle.
   always_comb begin
      state_d   = state_q;
      ack_d     = 1'b0;
      dat_d     = '0;
      wr_commit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d   = S_ACK;
               ack_d     = 1'b1;
               dat_d     = wbs_we_i ? 32'h0 : rd_data;
               wr_commit = wbs_we_i;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= S_IDLE;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         state_q   <= state_d;
         wbs_ack_o <= ack_d;
         wbs_dat_o <= dat_d;
      end
   end

   // Configuration registers; pad writes are frozen once lock is set.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         lock_q <= 1'b0;
         for (int p = 0; p < NUM_PADS; p++) begin
            cfg_q[p] <= '0;
         end
      end else if (wr_commit) begin
         if (ctrl_hit && wbs_sel_i[0] && wbs_dat_i[0]) begin
            lock_q <= 1'b1;
         end
         if (!lock_q) begin
            for (int p = 0; p < NUM_PADS; p++) begin
               if (word == WORD_W'(p)) begin
                  if (wbs_sel_i[0]) begin
                     cfg_q[p].sel <= wbs_dat_i[SEL_W-1:0];
                  end
                  if (wbs_sel_i[1]) begin
                     cfg_q[p].dir <= wbs_dat_i[BIT_DIR];
                     cfg_q[p].en  <= wbs_dat_i[BIT_EN];
                  end
               end
            end
         end
      end
   end

   // Fabric-to-pad path: only enabled outputs with an in-range index drive.
   always_comb begin
      io_out = '0;
      io_oeb = '1;
      for (int p = 0; p < NUM_PADS; p++) begin
         if (cfg_q[p].en && cfg_q[p].dir && (32'(cfg_q[p].sel) < NUM_FPGA_IO)) begin
            io_out[p] = fpga_out_ext[cfg_q[p].sel];
            io_oeb[p] = 1'b0;
         end
      end
   end

   // Pad-to-fabric path: wired-OR of every input pad mapped onto each index.
   always_comb begin
      fpga_in = '0;
      for (int i = 0; i < NUM_FPGA_IO; i++) begin
         for (int p = 0; p < NUM_PADS; p++) begin
            if (cfg_q[p].en && !cfg_q[p].dir && (cfg_q[p].sel == SEL_W'(i))) begin
               fpga_in[i] = fpga_in[i] | pad_in[p];
            end
         end
      end
   end

endmodule

// File: tb/tb_fpga_io_router.sv
// Directed bench for fpga_io_router; read data and handshake expectations flow through scoreboard queues.
// Honours IO_ROUTER_SYNC_EN for the pad-to-fabric latency.
module tb_fpga_io_router;

   localparam int unsigned NUM_PADS    = 38;
   localparam int unsigned NUM_FPGA_IO = 38;
   localparam logic [31:0] BASE        = 32'h3000_1000;

   logic                   clk;
   logic                   rst;
   logic                   wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]             wbs_sel_i;
   logic [31:0]            wbs_dat_i, wbs_adr_i;
   logic                   wbs_ack_o;
   logic [31:0]            wbs_dat_o;
   logic [NUM_FPGA_IO-1:0] fpga_out;
   logic [NUM_FPGA_IO-1:0] fpga_in;
   logic [NUM_PADS-1:0]    io_in;
   logic [NUM_PADS-1:0]    io_out;
   logic [NUM_PADS-1:0]    io_oeb;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic        exp_ack_q[$];
   logic        got;
   logic [31:0] rdata;

   fpga_io_router dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wbs_stb_i(wbs_stb_i),
      .wbs_cyc_i(wbs_cyc_i),
      .wbs_we_i (wbs_we_i),
      .wbs_sel_i(wbs_sel_i),
      .wbs_dat_i(wbs_dat_i),
      .wbs_adr_i(wbs_adr_i),
      .wbs_ack_o(wbs_ack_o),
      .wbs_dat_o(wbs_dat_o),
      .fpga_out (fpga_out),
      .fpga_in  (fpga_in),
      .io_in    (io_in),
      .io_out   (io_out),
      .io_oeb   (io_oeb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic ack_seen, output logic [31:0] rd);
      ack_seen = 1'b0;
      rd       = '0;
      @(negedge clk);
      wbs_adr_i = adr;
      wbs_we_i  = we;
      wbs_dat_i = dat;
      wbs_sel_i = sel;
      wbs_stb_i = 1'b1;
      wbs_cyc_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (wbs_ack_o) begin
            ack_seen = 1'b1;
            rd       = wbs_dat_o;
            break;
         end
      end
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_we_i  = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel,
                           input string tag);
      logic        a;
      logic [31:0] d;
      wb_cycle(BASE + off, 1'b1, dat, sel, a, d);
      check({tag, "_ack"}, 64'(a), 64'h1);
   endtask

   task automatic wb_read(input logic [31:0] off, input logic [31:0] exp, input string tag);
      logic        a;
      logic [31:0] d;
      logic [31:0] e;
      exp_q.push_back(exp);
      wb_cycle(BASE + off, 1'b0, 32'h0, 4'hF, a, d);
      e = exp_q.pop_front();
      if (a) check(tag, 64'(d), 64'(e));
      else   check({tag, "_ack"}, 64'(a), 64'h1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic settle_in();
`ifdef IO_ROUTER_SYNC_EN
      repeat (2) @(negedge clk);
`else
      #1;
`endif
   endtask

   initial begin
      rst       = 1'b1;
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'h0;
      wbs_dat_i = '0;
      wbs_adr_i = '0;
      fpga_out  = '0;
      io_in     = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("rst_ack", 64'(wbs_ack_o), 64'h0);
      check("rst_dat", 64'(wbs_dat_o), 64'h0);
      check("rst_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
      check("rst_out", 64'(io_out), 64'h0);
      check("rst_fin", 64'(fpga_in), 64'h0);
      wb_read(32'h000, 32'h0, "rst_rd0");

      // Output mapping: pad 10 <- fpga_out[5]
      wb_write(32'h028, 32'h0000_0305, 4'hF, "w_pad10");
      check("p10_oeb", 64'(io_oeb), 64'h3F_FFFF_FBFF);
      @(negedge clk); fpga_out[5] = 1'b1; #1;
      check("p10_out_hi", 64'(io_out), 64'h400);
      @(negedge clk); fpga_out[5] = 1'b0; #1;
      check("p10_out_lo", 64'(io_out), 64'h0);
      wb_read(32'h028, 32'h0000_0305, "rd_pad10");

      // Input fan-in: pads 30 and 31 -> index 7
      wb_write(32'h078, 32'h0000_0207, 4'hF, "w_pad30");
      wb_write(32'h07C, 32'h0000_0207, 4'hF, "w_pad31");
      check("in_oeb", 64'(io_oeb[31:30]), 64'h3);
      @(negedge clk); io_in[30] = 1'b1;
`ifdef IO_ROUTER_SYNC_EN
      @(negedge clk);
      check("in_sync_1cyc", 64'(fpga_in), 64'h0);
      @(negedge clk);
`else
      #1;
`endif
      check("in_p30", 64'(fpga_in), 64'h80);
      @(negedge clk); io_in[30] = 1'b0; io_in[31] = 1'b1;
      settle_in();
      check("in_p31", 64'(fpga_in), 64'h80);
      @(negedge clk); io_in = '0; io_in[0] = 1'b1;
      settle_in();
      check("in_off", 64'(fpga_in), 64'h0);
      io_in = '0;

      // Index range and byte lanes on pad 3, boundary indices on pads 4 and 5
      @(negedge clk); fpga_out = '1;
      wb_write(32'h00C, 32'h0000_032D, 4'hF, "w_pad3_oor");
      check("oor_oeb", 64'(io_oeb[3]), 64'h1);
      check("oor_out", 64'(io_out[3]), 64'h0);
      wb_read(32'h00C, 32'h0000_032D, "rd_pad3_oor");
      wb_write(32'h00C, 32'h0000_0105, 4'b0010, "w_pad3_lane1");
      wb_read(32'h00C, 32'h0000_012D, "rd_pad3_lane1");
      wb_write(32'h00C, 32'h0000_0301, 4'b0001, "w_pad3_lane0");
      wb_read(32'h00C, 32'h0000_0101, "rd_pad3_lane0");
      wb_write(32'h010, 32'h0000_0325, 4'hF, "w_pad4_idx37");
      wb_write(32'h014, 32'h0000_0326, 4'hF, "w_pad5_idx38");
      check("idx_edge_oeb", 64'(io_oeb[5:3]), 64'h5);
      check("idx_edge_out", 64'(io_out[5:3]), 64'h2);

      // Unmapped offsets
      wb_write(32'h098, 32'hFFFF_FFFF, 4'hF, "w_hole");
      wb_read(32'h098, 32'h0, "rd_hole_pad38");
      wb_read(32'h104, 32'h0, "rd_hole_104");

      // Lock
      wb_write(32'h100, 32'h0000_0001, 4'h1, "w_lock");
      wb_read(32'h100, 32'h1, "rd_lock");
      wb_write(32'h028, 32'h0, 4'hF, "w_locked_pad");
      wb_read(32'h028, 32'h0000_0305, "rd_locked_pad");
      check("locked_oeb10", 64'(io_oeb[10]), 64'h0);
      wb_write(32'h100, 32'h0, 4'hF, "w_lock0");
      wb_read(32'h100, 32'h1, "rd_lock_sticky");
      do_reset();
      wb_read(32'h100, 32'h0, "rd_lock_rst");
      wb_read(32'h028, 32'h0, "rd_pad10_rst");

      // Non-hit addresses
      wb_cycle(32'h3000_2028, 1'b0, 32'h0, 4'hF, got, rdata);
      check("nohit_a", 64'(got), 64'h0);
      wb_cycle(32'h2000_1028, 1'b1, 32'h305, 4'hF, got, rdata);
      check("nohit_b", 64'(got), 64'h0);
      wb_read(32'h028, 32'h0, "rd_nohit_nowrite");

      // Held strobe: ack every other cycle, data only alongside ack
      wb_write(32'h028, 32'h0000_0305, 4'hF, "w_pad10_hs");
      for (int k = 0; k < 6; k++) begin
         exp_ack_q.push_back(k[0]);
         exp_q.push_back(k[0] ? 32'h0000_0305 : 32'h0);
      end
      @(negedge clk);
      wbs_adr_i = BASE + 32'h028;
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'hF;
      wbs_stb_i = 1'b1;
      wbs_cyc_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check("hs_ack", 64'(wbs_ack_o), 64'(exp_ack_q.pop_front()));
         check("hs_dat", 64'(wbs_dat_o), 64'(exp_q.pop_front()));
         @(negedge clk);
      end
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      @(negedge clk);
      check("idle_dat", 64'(wbs_dat_o), 64'h0);

      // Reset during ACK: ack drops and the committed write is wiped
      @(negedge clk);
      wbs_adr_i = BASE + 32'h000;
      wbs_we_i  = 1'b1;
      wbs_dat_i = 32'h0000_0301;
      wbs_sel_i = 4'hF;
      wbs_stb_i = 1'b1;
      wbs_cyc_i = 1'b1;
      @(negedge clk);
      check("rstack_hi", 64'(wbs_ack_o), 64'h1);
      check("rstack_oeb0_pre", 64'(io_oeb[0]), 64'h0);
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_we_i  = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      check("rstack_lo", 64'(wbs_ack_o), 64'h0);
      check("rstack_oeb0", 64'(io_oeb[0]), 64'h1);
      rst = 1'b0;
      wb_read(32'h000, 32'h0, "rd_pad0_after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
